// File: rtl/nabp_shift_sequencer_if.sv
// rtl/nabp_shift_sequencer_if.sv - shift amount stream between sequencer and shifter datapath
interface nabp_shift_sequencer_if #(
  parameter int SHIFT_W = 12,
  parameter int LINE_W  = 10
);
  logic                shift_valid;
  logic                shift_ready;
  logic [SHIFT_W-1:0]  shift_value;
  logic [LINE_W-1:0]   shift_line;

  modport master (
    output shift_valid,
    input  shift_ready,
    output shift_value,
    output shift_line
  );

  modport slave (
    input  shift_valid,
    output shift_ready,
    input  shift_value,
    input  shift_line
  );
endinterface

// File: rtl/nabp_shift_sequencer.sv
// rtl/nabp_shift_sequencer.sv - LUT-driven per-line shift amount sequencer
module nabp_shift_sequencer #(
  parameter int ANGLE_W     = 8,
  parameter int ACCU_INT_W  = 2,
  parameter int ACCU_FRAC_W = 14,
  parameter int LINE_W      = 10,
  parameter int SHIFT_W     = 12
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [ANGLE_W-1:0]                  start_angle,
  input  logic [LINE_W-1:0]                   num_lines,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic [ANGLE_W-1:0]                  lut_angle,
  input  logic signed [ACCU_INT_W+ACCU_FRAC_W-1:0] lut_accu_base,
  nabp_shift_sequencer_if.master              shift_if
);

  localparam int BASE_W    = ACCU_INT_W + ACCU_FRAC_W;
  localparam int ACC_W     = BASE_W + LINE_W;
  localparam int ACC_INT_W = ACC_W - ACCU_FRAC_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_EMIT,
    S_FIN
  } state_t;

  state_t                    state_q, state_d;
  logic [ANGLE_W-1:0]        lut_angle_q, lut_angle_d;
  logic [LINE_W-1:0]         count_q, count_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic signed [BASE_W-1:0]  base_q, base_d;
  logic signed [ACC_W-1:0]   accu_q, accu_d;
  logic                      err_q, err_d;
  logic signed [ACC_INT_W-1:0] accu_int;
  logic                      angle_bad;

  assign angle_bad = (32'(start_angle) >= 32'd180);

  // Dropping the fraction bits of a signed value is floor, not truncation toward zero.
  assign accu_int = accu_q[ACC_W-1:ACCU_FRAC_W];

  always_comb begin
    state_d     = state_q;
    lut_angle_d = lut_angle_q;
    count_d     = count_q;
    line_d      = line_q;
    base_d      = base_q;
    accu_d      = accu_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (angle_bad) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (num_lines == '0) begin
            err_d   = 1'b0;
            state_d = S_FIN;
          end else begin
            err_d       = 1'b0;
            lut_angle_d = start_angle;
            count_d     = num_lines;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: state_d = S_CAP;
      S_CAP: begin
        base_d  = lut_accu_base;
        accu_d  = '0;
        line_d  = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (shift_if.shift_ready) begin
          if (line_q == count_q - LINE_W'(1)) begin
            state_d = S_FIN;
          end else begin
            line_d = line_q + LINE_W'(1);
            accu_d = accu_q + ACC_W'(base_q);
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      lut_angle_q <= '0;
      count_q     <= '0;
      line_q      <= '0;
      base_q      <= '0;
      accu_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lut_angle_q <= lut_angle_d;
      count_q     <= count_d;
      line_q      <= line_d;
      base_q      <= base_d;
      accu_q      <= accu_d;
      err_q       <= err_d;
    end
  end

  assign busy                 = (state_q != S_IDLE);
  assign done                 = (state_q == S_FIN);
  assign err                  = err_q;
  assign lut_angle            = lut_angle_q;
  assign shift_if.shift_valid = (state_q == S_EMIT);
  assign shift_if.shift_value = SHIFT_W'(accu_int);
  assign shift_if.shift_line  = line_q;

endmodule

// File: tb/tb_nabp_shift_sequencer.sv
// tb/tb_nabp_shift_sequencer.sv - directed vector bench for nabp_shift_sequencer
module tb_nabp_shift_sequencer;

  logic               clk;
  logic               reset_n;
  logic               start;
  logic [7:0]         start_angle;
  logic [9:0]         num_lines;
  logic               busy;
  logic               done;
  logic               err;
  logic [7:0]         lut_angle;
  logic signed [15:0] lut_accu_base;

  int n_pass;
  int n_total;
  int exp_vals [0:1023];

  nabp_shift_sequencer_if #(.SHIFT_W(12), .LINE_W(10)) sif ();

  nabp_shift_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .start_angle   (start_angle),
    .num_lines     (num_lines),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .lut_angle     (lut_angle),
    .lut_accu_base (lut_accu_base),
    .shift_if      (sif.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic signed [15:0] lut_fn(input logic [7:0] a);
    case (a)
      8'd30:   lut_fn = 16'sd9459;
      8'd45:   lut_fn = 16'sd16384;
      8'd60:   lut_fn = 16'sd28378;
      8'd135:  lut_fn = -16'sd16384;
      8'd150:  lut_fn = -16'sd9459;
      8'd179:  lut_fn = -16'sd32768;
      default: lut_fn = 16'sd0;
    endcase
  endfunction

  always @(posedge clk) lut_accu_base <= lut_fn(lut_angle);

  task automatic chk(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  task automatic run_cmd(input logic [7:0] ang, input int nl, input bit exp_err,
                         input bit gated, input bit poke);
    int k, cyc, first_cyc, last_cyc, done_cyc, exp_n;
    logic [7:0] prev_lut;
    bit finished;
    exp_n = exp_err ? 0 : nl;
    k = 0; cyc = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; finished = 0;
    @(negedge clk);
    prev_lut    = lut_angle;
    start       = 1'b1;
    start_angle = ang;
    num_lines   = nl[9:0];
    @(negedge clk);
    cyc = 1;
    while (!finished && cyc < 6000) begin
      start = 1'b0;
      sif.shift_ready = gated ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (sif.shift_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk("value", $signed(sif.shift_value), exp_vals[(k < 1024) ? k : 1023]);
        chk("line", int'(sif.shift_line), k);
        if (poke && k == 1) begin
          start       = 1'b1;
          start_angle = 8'd45;
          num_lines   = 10'd4;
        end
        if (sif.shift_ready) begin
          last_cyc = cyc;
          k++;
        end
      end
      if (done) begin
        done_cyc = cyc;
        finished = 1;
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen", int'(finished), 1);
    chk("transfers", k, exp_n);
    chk("err", int'(err), int'(exp_err));
    if (exp_n > 0) begin
      chk("first_latency", first_cyc, 3);
      chk("done_after_last", done_cyc, last_cyc + 1);
    end else begin
      chk("no_stream", first_cyc, -1);
      chk("done_latency", done_cyc, 1);
      chk("lut_angle_held", int'(lut_angle), int'(prev_lut));
    end
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("idle_after", int'(busy), 0);
    chk("err_hold", int'(err), int'(exp_err));
  endtask

  typedef struct packed {
    logic [7:0]             angle;
    logic [9:0]             nlines;
    logic                   err;
    logic                   gated;
    logic                   poke;
    logic [3:0][11:0]       expv;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    n_pass = 0;
    n_total = 0;
    reset_n = 1'b0;
    start = 1'b0;
    start_angle = '0;
    num_lines = '0;
    sif.shift_ready = 1'b0;

    vecs[0] = '{angle: 8'd45,  nlines: 10'd4, err: 1'b0, gated: 1'b0, poke: 1'b0,
                expv: {12'sd3, 12'sd2, 12'sd1, 12'sd0}};
    vecs[1] = '{angle: 8'd30,  nlines: 10'd4, err: 1'b0, gated: 1'b0, poke: 1'b1,
                expv: {12'sd1, 12'sd1, 12'sd0, 12'sd0}};
    vecs[2] = '{angle: 8'd150, nlines: 10'd4, err: 1'b0, gated: 1'b0, poke: 1'b0,
                expv: {-12'sd2, -12'sd2, -12'sd1, 12'sd0}};
    vecs[3] = '{angle: 8'd135, nlines: 10'd3, err: 1'b0, gated: 1'b1, poke: 1'b0,
                expv: {12'sd0, -12'sd2, -12'sd1, 12'sd0}};
    vecs[4] = '{angle: 8'd10,  nlines: 10'd0, err: 1'b0, gated: 1'b0, poke: 1'b0,
                expv: '0};
    vecs[5] = '{angle: 8'd200, nlines: 10'd4, err: 1'b1, gated: 1'b0, poke: 1'b0,
                expv: '0};

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_valid", int'(sif.shift_valid), 0);
    chk("rst_lut_angle", int'(lut_angle), 0);
    chk("rst_value", int'(sif.shift_value), 0);
    chk("rst_line", int'(sif.shift_line), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) exp_vals[j] = $signed(vecs[i].expv[j]);
      run_cmd(vecs[i].angle, int'(vecs[i].nlines), vecs[i].err, vecs[i].gated, vecs[i].poke);
    end

    // Reference model: exact product then floor division, independent of the running sum.
    for (int i = 0; i < 1023; i++) begin
      longint p, q;
      p = longint'(i) * -32768;
      q = p / 16384;
      if ((p % 16384 != 0) && (p < 0)) q = q - 1;
      exp_vals[i] = int'(q);
    end
    run_cmd(8'd179, 1023, 1'b0, 1'b0, 1'b0);

    begin
      int w;
      @(negedge clk);
      start = 1'b1; start_angle = 8'd60; num_lines = 10'd10;
      sif.shift_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (!(sif.shift_valid && sif.shift_line == 10'd5) && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("reached_line5", int'(w < 50), 1);
      #3 reset_n = 1'b0;
      #1;
      chk("arst_valid", int'(sif.shift_valid), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_line", int'(sif.shift_line), 0);
      chk("arst_value", int'(sif.shift_value), 0);
      chk("arst_lut_angle", int'(lut_angle), 0);
      @(negedge clk);
      chk("arst_no_done", int'(done), 0);
      reset_n = 1'b1;
    end

    for (int j = 0; j < 4; j++) exp_vals[j] = j;
    run_cmd(8'd45, 4, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
